// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: trace record layout,
// default sizes and the byte-lane merge used for both the RAM write and the trace word.
package dm_pkg;

    localparam int DM_DEFAULT_DEPTH_WORDS = 3072;
    localparam int DM_DEFAULT_TRACE_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } dm_trace_rec_t;

    // Lanes with byteen set take the new data; the rest keep the old word.
    function automatic logic [31:0] dm_merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  byteen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// Generic synchronous FIFO: push side, valid/ready pop side, full flag and a sticky
// overflow flag for pushes dropped while full. Asynchronous active-high reset.
module dm_trace_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             overflow_reg;
    logic             empty;
    logic             pop;
    logic             push_ok;

    // Extra MSB on the pointers separates full from empty when the indices match.
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_valid = !empty;
    assign pop       = pop_valid && pop_ready;
    assign push_ok   = push && (!full || pop);
    assign overflow  = overflow_reg;

    // Head data is forced to zero when empty so stale entries never leak out.
    assign pop_data = pop_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the MIPS M stage: async word read, byte-enabled write,
// range check, and (with DM_TRACE_EN defined) a store-trace FIFO drained by valid/ready.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEFAULT_DEPTH_WORDS,
    parameter int TRACE_DEPTH = DM_DEFAULT_TRACE_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_wdata,
    output logic [3:0]  trace_byteen,
    output logic        trace_overflow,
    output logic        addr_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] ram [DEPTH_WORDS];
    logic [29:0] word_idx;
    logic        in_range;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] old_word;
    logic [31:0] merged_word;
    logic        addr_err_reg;
    logic        unused_sig;

    assign word_idx    = m_data_addr[31:2];
    assign in_range    = ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    assign wr_req      = (m_data_byteen != 4'b0000);
    assign wr_en       = wr_req && in_range;
    assign old_word    = in_range ? ram[word_idx[IDX_W-1:0]] : 32'h0;
    assign merged_word = dm_merge_lanes(old_word, m_data_wdata, m_data_byteen);

    assign m_data_rdata = old_word;
    assign addr_err     = addr_err_reg;

    // RAM contents survive reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[word_idx[IDX_W-1:0]] <= merged_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_reg <= 1'b0;
        end else if (wr_req && !in_range) begin
            addr_err_reg <= 1'b1;
        end
    end

`ifdef DM_TRACE_EN
    dm_trace_rec_t push_rec;
    dm_trace_rec_t head_rec;
    logic          trace_full_unused;

    assign push_rec = '{pc:     m_inst_addr,
                        addr:   {m_data_addr[31:2], 2'b00},
                        wdata:  merged_word,
                        byteen: m_data_byteen};

    dm_trace_fifo #(
        .WIDTH($bits(dm_trace_rec_t)),
        .DEPTH(TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (push_rec),
        .pop_valid (trace_valid),
        .pop_ready (trace_ready),
        .pop_data  (head_rec),
        .full      (trace_full_unused),
        .overflow  (trace_overflow)
    );

    assign trace_pc     = head_rec.pc;
    assign trace_addr   = head_rec.addr;
    assign trace_wdata  = head_rec.wdata;
    assign trace_byteen = head_rec.byteen;
    assign unused_sig   = ^{m_data_addr[1:0], trace_full_unused};
`else
    assign trace_valid    = 1'b0;
    assign trace_overflow = 1'b0;
    assign trace_pc       = 32'h0;
    assign trace_addr     = 32'h0;
    assign trace_wdata    = 32'h0;
    assign trace_byteen   = 4'h0;
    assign unused_sig     = ^{m_data_addr[1:0], m_inst_addr, trace_ready, TRACE_DEPTH};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a RAM model plus a queue of expected trace
// records; records are queued as writes are driven and compared as they are popped.
`timescale 1ns/1ps
module tb_dm_responder;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_wdata;
    logic [3:0]  trace_byteen;
    logic        trace_overflow;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    dm_trace_rec_t exp_q[$];
    logic [31:0]   model_mem [int];
    logic          model_ovf;
    logic          model_err;

    always #5 clk = ~clk;

    dm_responder dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_wdata    (trace_wdata),
        .trace_byteen   (trace_byteen),
        .trace_overflow (trace_overflow),
        .addr_err       (addr_err)
    );

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[31:2]);
        if (addr[31:2] >= 30'd3072) return 32'h0;
        if (model_mem.exists(idx)) return model_mem[idx];
        return 32'h0;
    endfunction

    // One clock cycle of stimulus; scoreboard pops are compared before the edge.
    task automatic cycle(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc, input logic ready);
        bit            popping;
        dm_trace_rec_t head;
        dm_trace_rec_t rec;
        logic [31:0]   mask;
        logic [31:0]   old;
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        m_inst_addr   = pc;
        trace_ready   = ready;
        #1;
        checks++;
        if (trace_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL trace_valid: got %b want %b", trace_valid, exp_q.size() != 0);
        end
        popping = ready && (exp_q.size() != 0);
        if (popping) begin
            head = exp_q.pop_front();
            checks++;
            if ({trace_pc, trace_addr, trace_wdata, trace_byteen} !== head) begin
                errors++;
                $display("FAIL trace_record: got pc=%h addr=%h wdata=%h be=%h want pc=%h addr=%h wdata=%h be=%h",
                         trace_pc, trace_addr, trace_wdata, trace_byteen,
                         head.pc, head.addr, head.wdata, head.byteen);
            end
        end
        if (be != 4'b0000) begin
            if (addr[31:2] < 30'd3072) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                old  = model_read(addr);
                rec  = '{pc: pc, addr: {addr[31:2], 2'b00}, wdata: (old & ~mask) | (wdata & mask), byteen: be};
                model_mem[int'(addr[31:2])] = rec.wdata;
`ifdef DM_TRACE_EN
                if (exp_q.size() < 8) exp_q.push_back(rec);
                else model_ovf = 1'b1;
`endif
            end else begin
                model_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'h0;
        m_inst_addr   = 32'h0;
        trace_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
        model_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        m_data_addr = 32'h0;
        #1;
        checks++;
        if (m_data_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", m_data_rdata);
        end
        checks++;
        if ({trace_valid, trace_overflow, addr_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got v=%b ovf=%b err=%b want 000", trace_valid, trace_overflow, addr_err);
        end
        checks++;
        if ({trace_pc, trace_addr, trace_wdata, trace_byteen} !== 100'h0) begin
            errors++; $display("FAIL reset_trace_data: got %h want 0", {trace_pc, trace_addr, trace_wdata, trace_byteen});
        end
    endtask

    task automatic test_word_write();
        cycle(32'h10, 32'h12345678, 4'hF, 32'h0040_0020, 1'b0);
        #1;
        checks++;
        if (m_data_rdata !== 32'h12345678) begin
            errors++; $display("FAIL word_read: got %h want 12345678", m_data_rdata);
        end
`ifdef DM_TRACE_EN
        checks++;
        if ({trace_valid, trace_pc, trace_addr, trace_wdata, trace_byteen} !== {1'b1, 32'h0040_0020, 32'h10, 32'h12345678, 4'hF}) begin
            errors++; $display("FAIL word_record: got v=%b pc=%h addr=%h wdata=%h be=%h want v=1 pc=00400020 addr=10 wdata=12345678 be=f",
                               trace_valid, trace_pc, trace_addr, trace_wdata, trace_byteen);
        end
`endif
        cycle(32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_byte_merge();
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h00AB0000;
        m_data_byteen = 4'b0100;
        #1;
        checks++;
        if (m_data_rdata !== 32'h12345678) begin
            errors++; $display("FAIL same_cycle_old: got %h want 12345678", m_data_rdata);
        end
        cycle(32'h10, 32'h00AB0000, 4'b0100, 32'h0040_0024, 1'b0);
        #1;
        checks++;
        if (m_data_rdata !== 32'h12AB5678) begin
            errors++; $display("FAIL byte_merge: got %h want 12ab5678", m_data_rdata);
        end
        cycle(32'h10, 32'h000000EE, 4'b0001, 32'h0040_0028, 1'b1);
        #1;
        checks++;
        if (m_data_rdata !== 32'h12AB56EE) begin
            errors++; $display("FAIL byte_merge_lane0: got %h want 12ab56ee", m_data_rdata);
        end
        cycle(32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_out_of_range();
        cycle(32'h2FFC, 32'hCAFEF00D, 4'hF, 32'h0040_0030, 1'b1);
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL last_word_err: got %b want 0", addr_err);
        end
        cycle(32'h3000, 32'hDEADBEEF, 4'hF, 32'h0040_0034, 1'b1);
        cycle(32'h4000_0000, 32'h55555555, 4'hF, 32'h0040_0038, 1'b1);
        checks++;
        if (addr_err !== model_err) begin
            errors++; $display("FAIL addr_err: got %b want %b", addr_err, model_err);
        end
        m_data_addr = 32'h3000;
        #1;
        checks++;
        if (m_data_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_read: got %h want 0", m_data_rdata);
        end
        m_data_addr = 32'h2FFC;
        #1;
        checks++;
        if (m_data_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL last_word_read: got %h want cafef00d", m_data_rdata);
        end
        m_data_addr = 32'h0;
        #1;
        checks++;
        if (m_data_rdata !== model_read(32'h0)) begin
            errors++; $display("FAIL oor_alias: got %h want %h", m_data_rdata, model_read(32'h0));
        end
        cycle(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            cycle(32'h100 + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, 32'h0040_0100 + 32'(4 * i), 1'b0);
            if (i == 7) begin
                checks++;
                if (trace_overflow !== 1'b0) begin
                    errors++; $display("FAIL overflow_early: got %b want 0", trace_overflow);
                end
            end
        end
        checks++;
        if (trace_overflow !== model_ovf) begin
            errors++; $display("FAIL overflow_set: got %b want %b", trace_overflow, model_ovf);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
            if (exp_q.size() != 0) begin
                checks++;
                if (trace_pc !== exp_q[0].pc || trace_wdata !== exp_q[0].wdata) begin
                    errors++; $display("FAIL hold_stable: got pc=%h wdata=%h want pc=%h wdata=%h",
                                       trace_pc, trace_wdata, exp_q[0].pc, exp_q[0].wdata);
                end
            end
        end
        for (int i = 0; i < 9; i++) cycle(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        checks++;
        if (trace_overflow !== model_ovf) begin
            errors++; $display("FAIL overflow_sticky: got %b want %b", trace_overflow, model_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        checks++;
        if ({trace_overflow, addr_err} !== 2'b00) begin
            errors++; $display("FAIL reset_clears_sticky: got ovf=%b err=%b want 00", trace_overflow, addr_err);
        end
        for (int i = 0; i < 8; i++)
            cycle(32'h200 + 32'(4 * i), 32'h5A00_0000 | 32'(i), 4'hF, 32'h0040_0200 + 32'(4 * i), 1'b0);
        cycle(32'h220, 32'h5A00_0008, 4'b0011, 32'h0040_0220, 1'b1);
        checks++;
        if (trace_overflow !== 1'b0) begin
            errors++; $display("FAIL full_push_pop_ovf: got %b want 0", trace_overflow);
        end
        for (int i = 0; i < 7; i++) cycle(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({trace_valid, trace_overflow} !== 2'b00) begin
            errors++; $display("FAIL async_reset: got v=%b ovf=%b want 00", trace_valid, trace_overflow);
        end
        exp_q.delete();
        model_ovf = 1'b0;
        model_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            cycle(32'h300 + 32'(4 * i), 32'($urandom), 4'($urandom_range(1, 15)), 32'h0040_0300 + 32'(4 * i), 1'b1);
        for (int i = 0; i < 2; i++) cycle(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            m_data_addr = 32'h300 + 32'(4 * i);
            #1;
            checks++;
            if (m_data_rdata !== model_read(m_data_addr)) begin
                errors++; $display("FAIL b2b_read[%0d]: got %h want %h", i, m_data_rdata, model_read(m_data_addr));
            end
        end
        checks++;
        if (trace_overflow !== model_ovf) begin
            errors++; $display("FAIL b2b_overflow: got %b want %b", trace_overflow, model_ovf);
        end
    endtask

    initial begin
        model_ovf = 1'b0;
        model_err = 1'b0;
        test_reset();
        test_word_write();
        test_byte_merge();
        test_out_of_range();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
